block_tile_scheduler: RTL and testbench

- Sequences the 4x4 block multiplier across a full C = A x B job by issuing one tile command per (C-row tile, C-col tile, K tile) triple.
- Sits between the config/status reader and the A/B block fetch and C write-back engine.
- Latches matrix dimensions on start, validates them, walks tiles in row-major C order with K innermost, and waits for C write-back after each completed C tile.

---
 rtl/block_tile_scheduler_pkg.sv | 30 +++
 rtl/block_tile_scheduler_if.sv | 29 ++
 rtl/block_tile_scheduler_tile_dim_counter.sv | 39 +++
 rtl/block_tile_scheduler.sv | 171 +++++++++++++++++
 tb/tb_block_tile_scheduler.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/block_tile_scheduler_pkg.sv
// Shared constants, FSM encoding and the tile-extent helper for the block tile scheduler.
package tile_sched_pkg;

   localparam int DIM_W_DEF = 8;
   localparam int TILE      = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT_WB = 3'd3,
      S_DONE    = 3'd4
   } state_e;

   // Valid elements of a tile starting at base: min(TILE, dim - base), 0 past the end.
   function automatic logic [2:0] min_extent(input logic [15:0] dim, input logic [15:0] base);
      logic [15:0] diff;
      logic [2:0]  ext;
      diff = dim - base;
      if (dim <= base) begin
         ext = 3'd0;
      end else if (diff >= 16'(TILE)) begin
         ext = 3'(TILE);
      end else begin
         ext = diff[2:0];
      end
      return ext;
   endfunction

endpackage

// File: rtl/block_tile_scheduler_if.sv
// Tile command handshake between the scheduler (master) and the A/B fetch engine (slave).
interface block_tile_scheduler_if
   import tile_sched_pkg::*;
#(
   parameter int DIM_W = DIM_W_DEF
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [DIM_W-1:0] cmd_row;
   logic [DIM_W-1:0] cmd_col;
   logic [DIM_W-1:0] cmd_k;
   logic [2:0]       cmd_rows;
   logic [2:0]       cmd_cols;
   logic [2:0]       cmd_kext;
   logic             cmd_first;
   logic             cmd_last;

   modport master (
      output cmd_valid, cmd_row, cmd_col, cmd_k,
      output cmd_rows, cmd_cols, cmd_kext, cmd_first, cmd_last,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_row, cmd_col, cmd_k,
      input  cmd_rows, cmd_cols, cmd_kext, cmd_first, cmd_last,
      output cmd_ready
   );
endinterface

// File: rtl/block_tile_scheduler_tile_dim_counter.sv
// One tile index dimension: base steps by TILE on advance and wraps to 0 after its last tile.
module tile_dim_counter
   import tile_sched_pkg::*;
#(
   parameter int DIM_W = DIM_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             advance,
   input  logic [DIM_W-1:0] limit,
   output logic [DIM_W-1:0] index,
   output logic [2:0]       extent,
   output logic             is_last
);

   logic [DIM_W-1:0] index_r;
   logic [DIM_W:0]   reach_s;

   // One extra bit keeps base + TILE from wrapping near the top of the range.
   assign reach_s = {1'b0, index_r} + (DIM_W+1)'(TILE);
   assign is_last = (reach_s >= {1'b0, limit});
   assign extent  = min_extent(16'(limit), 16'(index_r));
   assign index   = index_r;

   // Base index register.
   always_ff @(posedge clock) begin
      if (reset) begin
         index_r <= '0;
      end else if (clear) begin
         index_r <= '0;
      end else if (advance) begin
         index_r <= is_last ? '0 : index_r + DIM_W'(TILE);
      end else begin
         index_r <= index_r;
      end
   end

endmodule

// File: rtl/block_tile_scheduler.sv
// Walks C = A x B in 4x4 tiles (row-major C, K innermost), issuing one command per tile triple.
// Optional TILE_SCHED_PERF_EN adds a saturating 16-bit stall_cnt output.
module block_tile_scheduler
   import tile_sched_pkg::*;
#(
   parameter int DIM_W = DIM_W_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [DIM_W-1:0]       a_rows,
   input  logic [DIM_W-1:0]       a_cols,
   input  logic [DIM_W-1:0]       b_rows,
   input  logic [DIM_W-1:0]       b_cols,
   block_tile_scheduler_if.master cmd,
   input  logic                   wb_done,
   output logic                   busy,
   output logic                   done,
   output logic                   size_err
`ifdef TILE_SCHED_PERF_EN
   ,
   output logic [15:0]            stall_cnt
`endif
);

   state_e           state_r;
   state_e           state_nxt_s;
   logic [DIM_W-1:0] a_rows_r, a_cols_r, b_rows_r, b_cols_r;
   logic             accept_s, dim_err_s, issue_s, wait_s, hs_s;
   logic             valid_s, busy_s, done_s, size_err_s;
   logic             col_adv_s, row_adv_s;
   logic [DIM_W-1:0] k_idx_s, col_idx_s, row_idx_s;
   logic [2:0]       k_ext_s, col_ext_s, row_ext_s;
   logic             k_last_s, col_last_s, row_last_s;

   assign accept_s  = (state_r == S_IDLE) && start;
   assign issue_s   = (state_r == S_ISSUE);
   assign wait_s    = (state_r == S_WAIT_WB);
   assign hs_s      = issue_s && cmd.cmd_ready;
   assign col_adv_s = wait_s && wb_done;
   assign row_adv_s = col_adv_s && col_last_s;
   assign dim_err_s = (a_cols_r != b_rows_r) || (a_rows_r == '0) || (a_cols_r == '0) ||
                      (b_rows_r == '0) || (b_cols_r == '0);

   // Dimension latch, loaded only when a start is accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_rows_r <= '0;
         a_cols_r <= '0;
         b_rows_r <= '0;
         b_cols_r <= '0;
      end else if (accept_s) begin
         a_rows_r <= a_rows;
         a_cols_r <= a_cols;
         b_rows_r <= b_rows;
         b_cols_r <= b_cols;
      end else begin
         a_rows_r <= a_rows_r;
         a_cols_r <= a_cols_r;
         b_rows_r <= b_rows_r;
         b_cols_r <= b_cols_r;
      end
   end

   // K wraps itself on the last K handshake, so it is already 0 when the C tile moves on.
   tile_dim_counter #(.DIM_W(DIM_W)) u_k_cnt (
      .clock(clock), .reset(reset), .clear(state_r == S_CHECK), .advance(hs_s),
      .limit(a_cols_r), .index(k_idx_s), .extent(k_ext_s), .is_last(k_last_s)
   );

   tile_dim_counter #(.DIM_W(DIM_W)) u_col_cnt (
      .clock(clock), .reset(reset), .clear(state_r == S_CHECK), .advance(col_adv_s),
      .limit(b_cols_r), .index(col_idx_s), .extent(col_ext_s), .is_last(col_last_s)
   );

   tile_dim_counter #(.DIM_W(DIM_W)) u_row_cnt (
      .clock(clock), .reset(reset), .clear(state_r == S_CHECK), .advance(row_adv_s),
      .limit(a_rows_r), .index(row_idx_s), .extent(row_ext_s), .is_last(row_last_s)
   );

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) state_nxt_s = S_CHECK;
            else       state_nxt_s = S_IDLE;
         end
         S_CHECK: begin
            if (dim_err_s) state_nxt_s = S_IDLE;
            else           state_nxt_s = S_ISSUE;
         end
         S_ISSUE: begin
            if (cmd.cmd_ready && k_last_s) state_nxt_s = S_WAIT_WB;
            else                           state_nxt_s = S_ISSUE;
         end
         S_WAIT_WB: begin
            if (wb_done && col_last_s && row_last_s) state_nxt_s = S_DONE;
            else if (wb_done)                        state_nxt_s = S_ISSUE;
            else                                     state_nxt_s = S_WAIT_WB;
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // FSM outputs, decoded from the registered state.
   always_comb begin
      valid_s    = 1'b0;
      busy_s     = 1'b0;
      done_s     = 1'b0;
      size_err_s = 1'b0;
      case (state_r)
         S_CHECK: begin
            busy_s     = 1'b1;
            size_err_s = dim_err_s;
         end
         S_ISSUE: begin
            busy_s  = 1'b1;
            valid_s = 1'b1;
         end
         S_WAIT_WB: busy_s = 1'b1;
         S_DONE:    done_s = 1'b1;
         default:   busy_s = 1'b0;
      endcase
   end

   assign busy     = busy_s;
   assign done     = done_s;
   assign size_err = size_err_s;

   // Fields are held at zero outside S_ISSUE so idle outputs read as 0.
   assign cmd.cmd_valid = valid_s;
   assign cmd.cmd_row   = issue_s ? row_idx_s : '0;
   assign cmd.cmd_col   = issue_s ? col_idx_s : '0;
   assign cmd.cmd_k     = issue_s ? k_idx_s   : '0;
   assign cmd.cmd_rows  = issue_s ? row_ext_s : 3'd0;
   assign cmd.cmd_cols  = issue_s ? col_ext_s : 3'd0;
   assign cmd.cmd_kext  = issue_s ? k_ext_s   : 3'd0;
   assign cmd.cmd_first = issue_s && (k_idx_s == '0);
   assign cmd.cmd_last  = issue_s && k_last_s;

`ifdef TILE_SCHED_PERF_EN
   logic [15:0] stall_cnt_r;

   // Stall counter: backpressured issue cycles plus write-back waits, saturating.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_r <= 16'd0;
      end else if (accept_s) begin
         stall_cnt_r <= 16'd0;
      end else if (((issue_s && !cmd.cmd_ready) || wait_s) && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_block_tile_scheduler.sv
// Directed, table-driven bench for block_tile_scheduler with a nested-loop command model.
module tb_block_tile_scheduler;

   typedef struct packed {
      logic [7:0] row;
      logic [7:0] col;
      logic [7:0] k;
      logic [2:0] rows;
      logic [2:0] cols;
      logic [2:0] kext;
      logic       first;
      logic       last;
   } cmd_t;

   typedef struct {
      int ar, ac, br, bc;
      int stall;
      int wbd;
      bit restart;
      bit exp_err;
      int exp_cmds;
   } vec_t;

   localparam int BUDGET = 60000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a_rows = 8'd0, a_cols = 8'd0, b_rows = 8'd0, b_cols = 8'd0;
   logic       wb_done = 1'b0;
   logic       busy, done, size_err;
`ifdef TILE_SCHED_PERF_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int failures = 0;
   vec_t vecs[10];
   cmd_t exp_q[$];

   block_tile_scheduler_if #(.DIM_W(8)) cmd_if ();

   block_tile_scheduler #(.DIM_W(8)) dut (
      .clock(clock), .reset(reset), .start(start),
      .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
      .cmd(cmd_if), .wb_done(wb_done),
      .busy(busy), .done(done), .size_err(size_err)
`ifdef TILE_SCHED_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic int ext4(input int dim, input int base);
      return ((dim - base) < 4) ? (dim - base) : 4;
   endfunction

   function automatic cmd_t sample_cmd();
      return {cmd_if.cmd_row, cmd_if.cmd_col, cmd_if.cmd_k, cmd_if.cmd_rows,
              cmd_if.cmd_cols, cmd_if.cmd_kext, cmd_if.cmd_first, cmd_if.cmd_last};
   endfunction

   task automatic run_job(input vec_t v);
      int   cyc, seen, dones, errs, err_cyc, stall_left, wb_cnt, n_tiles, total, exp_stall;
      bit   wb_pend, finished, prev_busy;
      cmd_t got, e;
      exp_q.delete();
      n_tiles = 0;
      if (!v.exp_err) begin
         for (int r = 0; r < v.ar; r += 4) begin
            for (int c = 0; c < v.bc; c += 4) begin
               n_tiles++;
               for (int k = 0; k < v.ac; k += 4) begin
                  e.row = 8'(r); e.col = 8'(c); e.k = 8'(k);
                  e.rows = 3'(ext4(v.ar, r)); e.cols = 3'(ext4(v.bc, c)); e.kext = 3'(ext4(v.ac, k));
                  e.first = (k == 0); e.last = (k + 4 >= v.ac);
                  exp_q.push_back(e);
               end
            end
         end
      end
      total = exp_q.size();
      exp_stall = total * v.stall + n_tiles * (v.wbd + 1);
      seen = 0; dones = 0; errs = 0; err_cyc = 0; wb_pend = 1'b0; wb_cnt = 0;
      finished = 1'b0; prev_busy = 1'b0; stall_left = v.stall;

      @(negedge clock);
      a_rows = 8'(v.ar); a_cols = 8'(v.ac); b_rows = 8'(v.br); b_cols = 8'(v.bc);
      start = 1'b1; cmd_if.cmd_ready = 1'b0; wb_done = 1'b0;
      cyc = 0;
      while (!finished && cyc < BUDGET) begin
         @(negedge clock);
         cyc++;
         start = 1'b0;
         if (v.restart && cyc == 3) begin
            start = 1'b1; a_rows = 8'd8; a_cols = 8'd8; b_rows = 8'd8; b_cols = 8'd8;
         end
         if (cyc == 1) check("busy_after_start", 64'(busy), 64'(1));
         if (size_err) begin
            errs++; err_cyc = cyc; finished = 1'b1;
         end
         if (done) begin
            dones++; finished = 1'b1;
            check("busy_at_done", 64'(busy), 64'(0));
            check("busy_before_done", 64'(prev_busy), 64'(1));
         end
         prev_busy = busy;
         if (wb_pend) begin
            if (wb_cnt == 0) begin wb_done = 1'b1; wb_pend = 1'b0; end
            else begin wb_done = 1'b0; wb_cnt--; end
         end else begin
            wb_done = 1'b0;
         end
         if (cmd_if.cmd_valid) begin
            got = sample_cmd();
            if (exp_q.size() == 0) check("cmd_count_over", 64'(seen + 1), 64'(total));
            else                   check("cmd_fields", 64'(got), 64'(exp_q[0]));
            if (stall_left > 0) begin
               cmd_if.cmd_ready = 1'b0; stall_left--;
            end else begin
               cmd_if.cmd_ready = 1'b1; seen++; stall_left = v.stall;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               if (got.last) begin wb_pend = 1'b1; wb_cnt = v.wbd; end
            end
         end else begin
            cmd_if.cmd_ready = 1'b0;
         end
      end
      wb_done = 1'b0; cmd_if.cmd_ready = 1'b0;
      check("job_finished", 64'(finished), 64'(1));
      check("size_err_count", 64'(errs), 64'(v.exp_err));
      if (v.exp_err) check("size_err_cycle", 64'(err_cyc), 64'(1));
      check("cmd_count", 64'(seen), 64'(v.exp_cmds));
      check("done_count", 64'(dones), 64'(!v.exp_err));
      repeat (3) begin
         @(negedge clock);
         check("idle_quiet", 64'({busy, done, size_err, cmd_if.cmd_valid}), 64'(0));
      end
`ifdef TILE_SCHED_PERF_EN
      check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
   endtask

   initial begin
      int dones;
      //          ar   ac   br   bc  stall wbd rst err cmds
      vecs[0] = '{4,   4,   4,   4,  0,    0,  0,  0,  1};
      vecs[1] = '{5,   6,   6,   3,  0,    1,  0,  0,  4};
      vecs[2] = '{4,   5,   4,   4,  0,    0,  0,  1,  0};
      vecs[3] = '{0,   4,   4,   4,  0,    0,  0,  1,  0};
      vecs[4] = '{8,   4,   4,   8,  3,    2,  0,  0,  4};
      vecs[5] = '{4,   255, 255, 4,  0,    0,  0,  0,  64};
      vecs[6] = '{255, 8,   8,   255, 0,   0,  0,  0,  8192};
      vecs[7] = '{4,   4,   4,   0,  0,    0,  0,  1,  0};
      vecs[8] = '{9,   1,   1,   2,  1,    0,  0,  0,  3};
      vecs[9] = '{4,   4,   4,   4,  3,    0,  1,  0,  1};

      cmd_if.cmd_ready = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_outputs", 64'({busy, done, size_err, cmd_if.cmd_valid}), 64'(0));
      check("reset_cmd_fields", 64'(sample_cmd()), 64'(0));
      reset = 1'b0;
      @(negedge clock);
      check("post_reset_idle", 64'({busy, done, size_err, cmd_if.cmd_valid}), 64'(0));

      // Reset while a command is backpressured must abort silently.
      a_rows = 8'd8; a_cols = 8'd4; b_rows = 8'd4; b_cols = 8'd8; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check("midjob_valid", 64'(cmd_if.cmd_valid), 64'(1));
      reset = 1'b1;
      @(negedge clock);
      check("midjob_reset_valid", 64'(cmd_if.cmd_valid), 64'(0));
      check("midjob_reset_busy", 64'(busy), 64'(0));
      reset = 1'b0;
      dones = 0;
      repeat (6) begin
         @(negedge clock);
         if (done) dones++;
      end
      check("midjob_no_done", 64'(dones), 64'(0));
      run_job(vecs[4]);

      for (int i = 0; i < 10; i++) run_job(vecs[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
